// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: shadows the E/M/W writers to derive stalls and
// operand forwarding selects, and times the multi-cycle mult/div unit.
module hazard_scoreboard #(
    parameter int ADDR_W      = 5,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] d_rs,
    input  logic [ADDR_W-1:0] d_rt,
    input  logic [1:0]        d_tuse_rs,
    input  logic [1:0]        d_tuse_rt,
    input  logic [ADDR_W-1:0] d_dst,
    input  logic [1:0]        d_tnew,
    input  logic              d_md_start,
    input  logic              d_md_div,
    input  logic              d_uses_hilo,
    output logic              stall,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic              fwd_rt_m,
    output logic              md_busy
);

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [1:0]        tnew;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
    } entry_t;

    localparam entry_t     BUBBLE    = '0;
    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES);

    // M keeps only what is still consulted downstream; W tnew is always 0.
    entry_t            e_q;
    logic [ADDR_W-1:0] m_dst;
    logic [ADDR_W-1:0] m_rt;
    logic [1:0]        m_tnew;
    logic [ADDR_W-1:0] w_dst;
    logic [7:0]        md_cnt;

    logic data_stall;
    logic md_stall;

    function automatic logic hit(
        input logic [ADDR_W-1:0] src,
        input logic [ADDR_W-1:0] dst
    );
        return (src != '0) && (src == dst);
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic src_stall(
        input logic [ADDR_W-1:0] src,
        input logic [1:0]        tuse,
        input entry_t            e,
        input logic [ADDR_W-1:0] mdst,
        input logic [1:0]        mtnew
    );
        if (tuse == 2'd3) return 1'b0;
        if (hit(src, e.dst)) return e.tnew > tuse;
        if (hit(src, mdst)) return mtnew > tuse;
        return 1'b0;
    endfunction

    function automatic logic [1:0] fwd_mw(
        input logic [ADDR_W-1:0] src,
        input logic [ADDR_W-1:0] mdst,
        input logic [1:0]        mtnew,
        input logic [ADDR_W-1:0] wdst
    );
        if (hit(src, mdst)) return (mtnew == 2'd0) ? 2'b10 : 2'b00;
        if (hit(src, wdst)) return 2'b11;
        return 2'b00;
    endfunction

    // Youngest match wins; a not-yet-ready youngest writer hides older ones.
    function automatic logic [1:0] fwd_emw(
        input logic [ADDR_W-1:0] src,
        input entry_t            e,
        input logic [ADDR_W-1:0] mdst,
        input logic [1:0]        mtnew,
        input logic [ADDR_W-1:0] wdst
    );
        if (hit(src, e.dst)) return (e.tnew == 2'd0) ? 2'b01 : 2'b00;
        return fwd_mw(src, mdst, mtnew, wdst);
    endfunction

    assign md_busy    = (md_cnt != 8'd0);
    assign md_stall   = (d_uses_hilo || d_md_start) && md_busy;
    assign data_stall = src_stall(d_rs, d_tuse_rs, e_q, m_dst, m_tnew)
                      | src_stall(d_rt, d_tuse_rt, e_q, m_dst, m_tnew);
    assign stall      = data_stall | md_stall;

    assign fwd_rs_d = fwd_emw(d_rs, e_q, m_dst, m_tnew, w_dst);
    assign fwd_rt_d = fwd_emw(d_rt, e_q, m_dst, m_tnew, w_dst);
    assign fwd_rs_e = fwd_mw(e_q.rs, m_dst, m_tnew, w_dst);
    assign fwd_rt_e = fwd_mw(e_q.rt, m_dst, m_tnew, w_dst);
    assign fwd_rt_m = hit(m_rt, w_dst);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q    <= BUBBLE;
            m_dst  <= '0;
            m_rt   <= '0;
            m_tnew <= 2'd0;
            w_dst  <= '0;
        end else begin
            w_dst  <= m_dst;
            m_dst  <= e_q.dst;
            m_rt   <= e_q.rt;
            m_tnew <= sat_dec(e_q.tnew);
            if (stall) begin
                e_q <= BUBBLE;
            end else begin
                e_q <= '{dst: d_dst, tnew: d_tnew, rs: d_rs, rt: d_rt};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= 8'd0;
        end else if (d_md_start && !stall) begin
            md_cnt <= d_md_div ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt != 8'd0) begin
            md_cnt <= md_cnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: pipeline-history model checked
// every cycle, plus literal expectations on the key scenarios.
module tb_hazard_scoreboard;

    localparam int AW = 5;
    localparam int MC = 5;
    localparam int DC = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] d_rs, d_rt, d_dst;
    logic [1:0]    d_tuse_rs, d_tuse_rt, d_tnew;
    logic          d_md_start, d_md_div, d_uses_hilo;
    logic          stall;
    logic [1:0]    fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic          fwd_rt_m, md_busy;

    int checks = 0;
    int passes = 0;

    hazard_scoreboard #(
        .ADDR_W(AW), .MULT_CYCLES(MC), .DIV_CYCLES(DC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_div(d_md_div),
        .d_uses_hilo(d_uses_hilo),
        .stall(stall),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
        .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s at %0t: got %0d expected %0d",
                      name, $time, act, exp);
    endtask

    // History of accepted instructions: slot 0 is E, 1 is M, 2 is W.
    typedef struct {
        int dst;
        int tnew;
        int rs;
        int rt;
    } ins_t;

    ins_t pipe[3];
    int   cyc = 0;
    int   md_done = 0;

    function automatic int remaining(int i);
        return (pipe[i].tnew > i) ? pipe[i].tnew - i : 0;
    endfunction

    function automatic int youngest(int src, int from);
        if (src == 0) return -1;
        for (int i = from; i < 3; i++)
            if (pipe[i].dst == src) return i;
        return -1;
    endfunction

    function automatic bit m_src_stall(int src, int tuse);
        int i;
        if (tuse == 3) return 1'b0;
        i = youngest(src, 0);
        if (i < 0) return 1'b0;
        return remaining(i) > tuse;
    endfunction

    function automatic bit m_busy();
        return cyc < md_done;
    endfunction

    function automatic bit m_stall();
        return m_src_stall(int'(d_rs), int'(d_tuse_rs))
            || m_src_stall(int'(d_rt), int'(d_tuse_rt))
            || ((d_uses_hilo || d_md_start) && m_busy());
    endfunction

    function automatic int m_fwd(int src, int from);
        int i;
        i = youngest(src, from);
        return (i >= 0 && remaining(i) == 0) ? i + 1 : 0;
    endfunction

    function automatic bit m_fwd_rt_m();
        return pipe[1].rt != 0 && pipe[1].rt == pipe[2].dst;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] <= '{0, 0, 0, 0};
            md_done <= 0;
        end else begin
            if (d_md_start && !m_stall())
                md_done <= cyc + 1 + (d_md_div ? DC : MC);
            pipe[2] <= pipe[1];
            pipe[1] <= pipe[0];
            if (m_stall()) pipe[0] <= '{0, 0, 0, 0};
            else pipe[0] <= '{int'(d_dst), int'(d_tnew),
                              int'(d_rs), int'(d_rt)};
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        check("m_stall", int'(stall), int'(m_stall()));
        check("m_fwd_rs_d", int'(fwd_rs_d), m_fwd(int'(d_rs), 0));
        check("m_fwd_rt_d", int'(fwd_rt_d), m_fwd(int'(d_rt), 0));
        check("m_fwd_rs_e", int'(fwd_rs_e), m_fwd(pipe[0].rs, 1));
        check("m_fwd_rt_e", int'(fwd_rt_e), m_fwd(pipe[0].rt, 1));
        check("m_fwd_rt_m", int'(fwd_rt_m), int'(m_fwd_rt_m()));
        check("m_md_busy", int'(md_busy), int'(m_busy()));
    end

    task automatic drive(input int rs, input int trs, input int rt,
                         input int trt, input int dst, input int tnew,
                         input bit st, input bit dv, input bit hl);
        d_rs        = AW'(rs);
        d_tuse_rs   = 2'(trs);
        d_rt        = AW'(rt);
        d_tuse_rt   = 2'(trt);
        d_dst       = AW'(dst);
        d_tnew      = 2'(tnew);
        d_md_start  = st;
        d_md_div    = dv;
        d_uses_hilo = hl;
    endtask

    task automatic step(input int rs, input int trs, input int rt,
                        input int trt, input int dst, input int tnew,
                        input bit st, input bit dv, input bit hl);
        @(posedge clk);
        #1;
        drive(rs, trs, rt, trt, dst, tnew, st, dv, hl);
        @(negedge clk);
    endtask

    task automatic nop();
        step(0, 3, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        drive(0, 3, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_stall", int'(stall), 0);
        check("rst_fwd_rs_d", int'(fwd_rs_d), 0);
        check("rst_busy", int'(md_busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // load r8 then dependent add
        step(0, 3, 0, 3, 8, 2, 1'b0, 1'b0, 1'b0);
        check("load_issue_stall", int'(stall), 0);
        step(8, 1, 0, 3, 10, 0, 1'b0, 1'b0, 1'b0);
        check("add_stall", int'(stall), 1);
        step(8, 1, 0, 3, 10, 0, 1'b0, 1'b0, 1'b0);
        check("add_released", int'(stall), 0);
        nop();
        check("add_fwd_rs_e", int'(fwd_rs_e), 3);

        // ALU r9 then beq
        step(0, 3, 0, 3, 9, 1, 1'b0, 1'b0, 1'b0);
        step(9, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        check("beq_stall", int'(stall), 1);
        step(9, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        check("beq_released", int'(stall), 0);
        check("beq_fwd_rs_d", int'(fwd_rs_d), 2);

        // jal then jr
        step(0, 3, 0, 3, 31, 0, 1'b0, 1'b0, 1'b0);
        step(31, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        check("jr_stall", int'(stall), 0);
        check("jr_fwd_rs_d", int'(fwd_rs_d), 1);

        // r0 never a source; two writers of r5
        step(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("r0_stall", int'(stall), 0);
        check("r0_fwd_rs_d", int'(fwd_rs_d), 0);
        step(0, 3, 0, 3, 5, 0, 1'b0, 1'b0, 1'b0);
        step(0, 3, 0, 3, 5, 0, 1'b0, 1'b0, 1'b0);
        step(5, 0, 5, 1, 6, 0, 1'b0, 1'b0, 1'b0);
        check("r5_fwd_rs_d", int'(fwd_rs_d), 1);
        check("r5_fwd_rt_d", int'(fwd_rt_d), 1);
        nop();
        check("r5_fwd_rs_e", int'(fwd_rs_e), 2);
        check("r5_fwd_rt_e", int'(fwd_rt_e), 2);

        // store data from W
        step(0, 3, 0, 3, 7, 0, 1'b0, 1'b0, 1'b0);
        step(0, 3, 7, 2, 0, 0, 1'b0, 1'b0, 1'b0);
        nop();
        check("st_fwd_rt_e", int'(fwd_rt_e), 2);
        nop();
        check("st_fwd_rt_m", int'(fwd_rt_m), 1);

        // divide then mfhi
        step(0, 3, 0, 3, 0, 0, 1'b1, 1'b1, 1'b0);
        check("div_issue_stall", int'(stall), 0);
        check("div_issue_busy", int'(md_busy), 0);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            step(0, 3, 0, 3, 2, 0, 1'b0, 1'b0, 1'b1);
            if (!md_busy) break;
            if (stall) n++;
        end
        check("div_stall_cycles", n, DC);
        check("mfhi_released", int'(stall), 0);

        // mult, then a second mult held until the first drains
        step(0, 3, 0, 3, 0, 0, 1'b1, 1'b0, 1'b0);
        check("mult_issue_stall", int'(stall), 0);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            step(0, 3, 0, 3, 0, 0, 1'b1, 1'b0, 1'b0);
            if (!md_busy) break;
            if (stall) n++;
        end
        check("mult_held_cycles", n, MC);
        check("mult_reissue_stall", int'(stall), 0);
        nop();
        check("mult_reloaded", int'(md_busy), 1);
        for (int k = 0; k < MC + 2; k++) nop();
        check("mult_drained", int'(md_busy), 0);

        // reset in the middle of a divide
        step(0, 3, 0, 3, 0, 0, 1'b1, 1'b1, 1'b0);
        step(0, 3, 0, 3, 12, 0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_busy", int'(md_busy), 1);
        @(posedge clk);
        #1;
        drive(12, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("in_rst_busy", int'(md_busy), 0);
        check("in_rst_stall", int'(stall), 0);
        check("in_rst_fwd_rs_d", int'(fwd_rs_d), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", int'(md_busy), 0);
        check("post_rst_stall", int'(stall), 0);
        check("post_rst_fwd_rs_d", int'(fwd_rs_d), 0);
        nop();
        nop();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL: parameter ADDR_W, default 5, register-address width; register 0 never a hazard source.
REQ-002 SHALL: parameter MULT_CYCLES, default 5, multiply busy duration in cycles (1..255).
REQ-003 SHALL: parameter DIV_CYCLES, default 10, divide busy duration in cycles (1..255).
REQ-004 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL: d_rs, d_rt  in  ADDR_W each  source registers of the instruction in D.
REQ-007 SHALL: d_tuse_rs, d_tuse_rt  in  2 each  stage needing the source (0=D, 1=E, 2=M, 3=unused).
REQ-008 SHALL: d_dst  in  ADDR_W  destination of D instruction (0 = no write).
REQ-009 SHALL: d_tnew  in  2  stage producing the result, counted from E (0=E, 1=M, 2=W).
REQ-010 SHALL: d_md_start, d_md_div, d_uses_hilo  in  1 each  D starts mult/div, start is divide, D reads/writes HI/LO.
REQ-011 SHALL: stall  out  1  hold PC and IF/ID, insert bubble into E.
REQ-012 SHALL: fwd_rs_d, fwd_rt_d  out  2 each  D-operand source (00=RF, 01=E, 10=M, 11=W).
REQ-013 SHALL: fwd_rs_e, fwd_rt_e  out  2 each  E-operand source (00=RF/ID-EX, 10=M, 11=W; 01 unused).
REQ-014 SHALL: fwd_rt_m  out  1  store data from W.
REQ-015 SHALL: md_busy  out  1  mult/div unit occupied.

Function
REQ-016 SHALL: keep shadow entries E, M, W, each {dst, tnew, rs, rt}; on each edge W<=M, M<=E with tnew saturating-decremented, E<=D fields with tnew=d_tnew, or a bubble (dst=0, tnew=0, rs=rt=0) when stall=1.
REQ-017 SHALL: W-stage tnew is always 0 after shift (saturated).
REQ-018 SHALL: a "match" of source s against stage X require s!=0 and s==X.dst.
REQ-019 SHALL: raise data stall when, for rs or rt with tuse!=3, a match exists in E with E.tnew>tuse, or in M with decremented M.tnew>tuse; youngest match only (E over M over W).
REQ-020 SHALL: fwd_*_d select youngest matching stage among E,M,W whose tnew==0, else 00; combinational.
REQ-021 SHALL: fwd_*_e compare E.rs/E.rt against M then W (tnew==0), youngest first; fwd_rt_m compare M.rt against W.
REQ-022 SHALL: md counter (8 bit) load MULT_CYCLES or DIV_CYCLES when d_md_start=1 and stall=0; decrement by 1 each cycle while nonzero.
REQ-023 SHALL: md_busy = (counter!=0), registered.
REQ-024 SHALL: raise md stall when d_uses_hilo=1 or d_md_start=1 and md_busy=1.
REQ-025 SHALL: stall = data stall OR md stall; a stalled d_md_start must not load the counter.
REQ-026 SHALL: counter reaching 0 and a new start in the same cycle: new start accepted (busy is registered, so stall already 0), counter reloads.
REQ-027 SHALL: outputs purely functions of current inputs and registered state; no stall latency beyond same cycle.

Reset
REQ-028 SHALL: on rst_n=0, immediately clear all entries to bubble and counter to 0; stall=0, all fwd=00, md_busy=0 while reset asserted with D inputs zero.
REQ-029 SHALL: reset asserted mid-divide abort the busy period; first cycle after release md_busy=0.

Verification
REQ-030 SHALL: load (d_dst=8,d_tnew=2) then add (d_rs=8,tuse=1) -> stall=1 one cycle, then fwd_rs_e=11 next cycle.
REQ-031 SHALL: ALU (dst=9,tnew=1) then beq (rs=9,tuse=0) -> stall=1 one cycle, then fwd_rs_d=10.
REQ-032 SHALL: jal (dst=31,tnew=0) then jr (rs=31,tuse=0) -> stall=0, fwd_rs_d=01.
REQ-033 SHALL: div start (DIV_CYCLES=10) then mfhi -> md_busy=1 for 10 cycles, mfhi stalled until md_busy=0.
REQ-034 SHALL: d_rs=0 against writer dst=0 -> stall=0, fwd=00; two writers to r5 in E and M -> fwd selects E.
REQ-035 SHALL: rst_n low for one cycle during divide busy -> md_busy=0, entries cleared, stall=0.
